sigma_delta_dac: RTL and testbench

- Transmit-side counterpart of the sigma-delta ADC.
- Accepts PCM samples at the decimated rate over a valid/ready handshake and interpolates them to the clock rate (zero-order hold or linear ramp).
- Drives a 1-bit sigma-delta modulator whose output pin feeds an external RC low-pass filter.
- Sits at the audio/control output path, mirroring the ADC's OVERSAMPLE_RATE framing.

---
 rtl/sigma_delta_dac_if.sv | 20 ++
 rtl/sigma_delta_dac.sv | 156 +++++++++++++++
 tb/tb_sigma_delta_dac.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sigma_delta_dac_if.sv
// Sample handshake between a PCM source (master) and the sigma-delta DAC (slave).
interface sigma_delta_dac_if #(
    parameter int unsigned DAC_BITLEN = 16
);
    logic [DAC_BITLEN-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/sigma_delta_dac.sv
// Sigma-delta DAC: one-entry sample buffer, frame-rate interpolator and a
// first- or second-order 1-bit modulator driving an external RC filter.
module sigma_delta_dac #(
    parameter int unsigned OVERSAMPLE_RATE = 256,
    parameter int unsigned DAC_BITLEN      = 16,
    parameter bit          SIGNED_INPUT    = 1'b1,
    parameter int unsigned MOD_ORDER       = 1,
    parameter bit          INTERP          = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    sigma_delta_dac_if.slave bus,
    output logic             dac_pin,
    output logic             frame_strobe,
    output logic             underrun
);
    localparam int unsigned LOG2 = $clog2(OVERSAMPLE_RATE);
    localparam int unsigned N    = DAC_BITLEN;

    if (MOD_ORDER != 1 && MOD_ORDER != 2) begin : g_bad_order
        $error("sigma_delta_dac: MOD_ORDER must be 1 or 2");
    end
    if (OVERSAMPLE_RATE < 4 || (1 << LOG2) != OVERSAMPLE_RATE) begin : g_bad_osr
        $error("sigma_delta_dac: OVERSAMPLE_RATE must be a power of 2 and >= 4");
    end

    logic [LOG2-1:0]     frame_cnt_q;
    logic                boundary;
    logic                buf_full_q;
    logic                accept;
    logic signed [N-1:0] buf_q;
    logic signed [N-1:0] target_q;
    logic signed [N-1:0] in_signed;
    logic signed [N-1:0] x;

    // Offset-binary input becomes two's complement by flipping the MSB.
    assign in_signed    = bus.in_data ^ {~SIGNED_INPUT, {(N-1){1'b0}}};
    assign bus.in_ready = ~buf_full_q;
    assign accept       = bus.in_valid & ~buf_full_q;
    // Frame length is a power of two, so the last count is all ones.
    assign boundary     = &frame_cnt_q;

    // Frame counter, input buffer, target sample and frame status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q  <= '0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            target_q     <= '0;
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_q + 1'b1;
            frame_strobe <= boundary;
            underrun     <= boundary & ~buf_full_q;
            if (boundary && buf_full_q) begin
                target_q   <= buf_q;
                buf_full_q <= 1'b0;
            end else if (accept) begin
                buf_q      <= in_signed;
                buf_full_q <= 1'b1;
            end
        end
    end

    if (INTERP) begin : g_linear
        logic signed [N-1:0] base_q;
        logic [N:0]          delta_q;
        logic [N+LOG2:0]     acc_q;
        logic [N-1:0]        next_target;
        logic [N+1:0]        ramp;

        assign next_target = buf_full_q ? buf_q : target_q;
        // acc_q[N+LOG2:LOG2] is acc >>> LOG2; one more sign bit makes room for the add.
        assign ramp = {{2{base_q[N-1]}}, base_q} + {acc_q[N+LOG2], acc_q[N+LOG2:LOG2]};

        // Ramp state: base restarts at each boundary, slope accumulates every clock.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                base_q  <= '0;
                delta_q <= '0;
                acc_q   <= '0;
            end else if (boundary) begin
                base_q  <= target_q;
                delta_q <= {next_target[N-1], next_target} - {target_q[N-1], target_q};
                acc_q   <= '0;
            end else begin
                acc_q   <= acc_q + {{LOG2{delta_q[N]}}, delta_q};
            end
        end

        // Clamp the interpolated value into the N-bit signed range.
        always_comb begin
            x = ramp[N-1:0];
            if (ramp[N+1:N-1] != '0 && ramp[N+1:N-1] != '1) begin
                x = {ramp[N+1], {(N-1){~ramp[N+1]}}};
            end
        end
    end else begin : g_hold
        assign x = target_q;
    end

    if (MOD_ORDER == 2) begin : g_mod2
        logic [N:0]   fb;
        logic [N+2:0] i1_sum;
        logic [N+1:0] i1_d;
        logic [N+1:0] i1_q;
        logic [N+4:0] i2_sum;
        logic [N+3:0] i2_d;
        logic [N+3:0] i2_q;

        // Two cascaded integrators with saturation instead of wrap-around.
        always_comb begin
            fb     = dac_pin ? {2'b01, {(N-1){1'b0}}} : {2'b11, {(N-1){1'b0}}};
            i1_sum = {i1_q[N+1], i1_q} + {{3{x[N-1]}}, x} - {{2{fb[N]}}, fb};
            i1_d   = i1_sum[N+1:0];
            if (i1_sum[N+2] != i1_sum[N+1]) begin
                i1_d = {i1_sum[N+2], {(N+1){~i1_sum[N+2]}}};
            end
            i2_sum = {i2_q[N+3], i2_q} + {{3{i1_d[N+1]}}, i1_d} - {{4{fb[N]}}, fb};
            i2_d   = i2_sum[N+3:0];
            if (i2_sum[N+4] != i2_sum[N+3]) begin
                i2_d = {i2_sum[N+4], {(N+3){~i2_sum[N+4]}}};
            end
        end

        // Integrator state and quantizer output.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                i1_q    <= '0;
                i2_q    <= '0;
                dac_pin <= 1'b0;
            end else begin
                i1_q    <= i1_d;
                i2_q    <= i2_d;
                dac_pin <= ~i2_d[N+3];
            end
        end
    end else begin : g_mod1
        logic [N-1:0] acc1_q;
        logic [N:0]   acc1_d;

        assign acc1_d = {1'b0, acc1_q} + {1'b0, x ^ {1'b1, {(N-1){1'b0}}}};

        // Phase accumulator; its carry is the output bitstream.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                acc1_q  <= '0;
                dac_pin <= 1'b0;
            end else begin
                acc1_q  <= acc1_d[N-1:0];
                dac_pin <= acc1_d[N];
            end
        end
    end
endmodule

// File: tb/tb_sigma_delta_dac.sv
// Directed bench: ZOH/first-order, linear/first-order and ZOH/second-order
// instances share one sample stream and one clock/reset.
module tb_sigma_delta_dac;
    localparam int unsigned OSR = 16;
    localparam int unsigned N   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] drv_data = '0;
    logic        drv_valid = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;

    logic pin_a, strobe_a, under_a;
    logic pin_b, strobe_b, under_b;
    logic pin_c, strobe_c, under_c;

    sigma_delta_dac_if #(.DAC_BITLEN(N)) if_a ();
    sigma_delta_dac_if #(.DAC_BITLEN(N)) if_b ();
    sigma_delta_dac_if #(.DAC_BITLEN(N)) if_c ();

    assign if_a.in_data  = drv_data;
    assign if_a.in_valid = drv_valid;
    assign if_b.in_data  = drv_data;
    assign if_b.in_valid = drv_valid;
    assign if_c.in_data  = drv_data;
    assign if_c.in_valid = drv_valid;

    sigma_delta_dac #(.OVERSAMPLE_RATE(OSR), .DAC_BITLEN(N), .SIGNED_INPUT(1'b1),
                      .MOD_ORDER(1), .INTERP(1'b0)) u_a (
        .clk(clk), .rst(rst), .bus(if_a),
        .dac_pin(pin_a), .frame_strobe(strobe_a), .underrun(under_a));

    sigma_delta_dac #(.OVERSAMPLE_RATE(OSR), .DAC_BITLEN(N), .SIGNED_INPUT(1'b1),
                      .MOD_ORDER(1), .INTERP(1'b1)) u_b (
        .clk(clk), .rst(rst), .bus(if_b),
        .dac_pin(pin_b), .frame_strobe(strobe_b), .underrun(under_b));

    sigma_delta_dac #(.OVERSAMPLE_RATE(OSR), .DAC_BITLEN(N), .SIGNED_INPUT(1'b1),
                      .MOD_ORDER(2), .INTERP(1'b0)) u_c (
        .clk(clk), .rst(rst), .bus(if_c),
        .dac_pin(pin_c), .frame_strobe(strobe_c), .underrun(under_c));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic to_boundary();
        do step(); while (cyc % OSR != 0);
    endtask

    task automatic push(input logic [15:0] v);
        int guard = 0;
        while (!if_a.in_ready && guard < 64) begin
            step();
            guard++;
        end
        if (!if_a.in_ready) begin
            n_checks++;
            n_err++;
            $error("FAIL push_timeout: observed in_ready=0 expected 1");
        end
        drv_data  = v;
        drv_valid = 1'b1;
        step();
        drv_valid = 1'b0;
    endtask

    task automatic count_ones(input int len, output int ones_a, output int ones_c);
        ones_a = 0;
        ones_c = 0;
        for (int i = 0; i < len; i++) begin
            step();
            ones_a += int'(pin_a);
            ones_c += int'(pin_c);
        end
    endtask

    initial begin
        int flags;
        int bad_s;
        int bad_u;
        int ones_a;
        int ones_c;
        int pulses;
        int rdy_bad;
        int rdy_hi;
        int ramp_bad;
        int start;
        logic [15:0] next_val;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 16'(if_a.in_ready), 16'h1);
        check("rst_dac_pin", 16'(pin_a), 16'h0);
        check("rst_strobe", 16'(strobe_a), 16'h0);
        check("rst_underrun", 16'(under_a), 16'h0);
        rst = 1'b1;
        cyc = 0;
        check("post_rst_dac_pin", 16'(pin_a), 16'h0);

        flags = 0;
        repeat (15) begin
            step();
            flags += int'(strobe_a) + int'(under_a);
        end
        check("no_pulse_before_boundary", 16'(flags), 16'h0);
        step();
        check("first_strobe", 16'(strobe_a), 16'h1);
        check("first_underrun", 16'(under_a), 16'h1);
        step();
        check("strobe_one_clock", 16'(strobe_a), 16'h0);

        // Reset mid-frame with the buffer full
        push(16'h1234);
        check("buffer_busy", 16'(if_a.in_ready), 16'h0);
        step();
        step();
        rst = 1'b0;
        #2;
        check("midrst_in_ready", 16'(if_a.in_ready), 16'h1);
        check("midrst_dac_pin", 16'(pin_a), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        bad_s = 0;
        bad_u = 0;
        repeat (32) begin
            step();
            if (strobe_a !== (cyc % OSR == 0)) bad_s++;
            if (under_a !== (cyc % OSR == 0)) bad_u++;
        end
        check("strobe_period", 16'(bad_s), 16'h0);
        check("underrun_after_midrst", 16'(bad_u), 16'h0);
        check("midrst_discard", u_a.x, 16'h0000);

        // First-order DC density
        push(16'h4000);
        to_boundary();
        check("zoh_x_4000", u_a.x, 16'h4000);
        step();
        count_ones(1024, ones_a, ones_c);
        check_range("density_4000", ones_a, 767, 769);
        push(16'h8000);
        to_boundary();
        step();
        count_ones(1024, ones_a, ones_c);
        check_range("density_8000", ones_a, 0, 1);
        push(16'h0000);
        to_boundary();
        step();
        count_ones(1024, ones_a, ones_c);
        check_range("density_0000", ones_a, 511, 513);

        // Underrun: hold 0x1000 over empty frames, then resume
        push(16'h1000);
        to_boundary();
        check("x_1000", u_a.x, 16'h1000);
        check("no_underrun_when_full", 16'(under_a), 16'h0);
        for (int f = 0; f < 3; f++) begin
            pulses = 0;
            repeat (OSR) begin
                step();
                pulses += int'(under_a);
            end
            check("underrun_per_frame", 16'(pulses), 16'h1);
            check("underrun_hold_x", u_a.x, 16'h1000);
        end
        push(16'h2000);
        to_boundary();
        check("resume_no_underrun", 16'(under_a), 16'h0);
        check("resume_x", u_a.x, 16'h2000);

        // Back-pressure: in_valid held high, data advances on each accept
        rdy_bad = 0;
        rdy_hi = 0;
        start = cyc;
        next_val = 16'h0100;
        drv_data = next_val;
        drv_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            logic took;
            took = if_a.in_ready;
            if (if_a.in_ready !== (k % OSR == 0)) rdy_bad++;
            rdy_hi += int'(if_a.in_ready);
            step();
            if (took) begin
                next_val = next_val + 16'h0100;
                drv_data = next_val;
            end
            if ((cyc - start) % OSR == 0) begin
                check("bp_target", u_a.x, 16'(((cyc - start) / OSR) * 'h100));
            end
        end
        drv_valid = 1'b0;
        check("bp_ready_pattern", 16'(rdy_bad), 16'h0);
        check("bp_accepts", 16'(rdy_hi), 16'h4);

        // Linear ramp 0 -> 0x0100
        push(16'h0000);
        to_boundary();
        push(16'h0100);
        to_boundary();
        check("zoh_latency", u_a.x, 16'h0100);
        ramp_bad = 0;
        for (int k = 0; k <= 16; k++) begin
            if (u_b.x !== 16'(k * 'h10)) ramp_bad++;
            if (k == 8) check("ramp_mid", u_b.x, 16'h0080);
            if (k < 16) step();
        end
        check("ramp_steps", 16'(ramp_bad), 16'h0);
        check("ramp_end", u_b.x, 16'h0100);
        step();
        check("ramp_hold", u_b.x, 16'h0100);
        to_boundary();

        // Second-order near full scale, then back to mid-scale
        push(16'h7FFF);
        to_boundary();
        repeat (256) step();
        count_ones(4096, ones_a, ones_c);
        check_range("o1_density_7fff", ones_a, 4095, 4096);
        check_range("o2_density_7fff", ones_c, 4055, 4096);
        push(16'h8001);
        to_boundary();
        repeat (256) step();
        count_ones(4096, ones_a, ones_c);
        check_range("o1_density_8001", ones_a, 0, 1);
        check_range("o2_density_8001", ones_c, 0, 41);
        push(16'h0000);
        to_boundary();
        repeat (512) step();
        count_ones(1024, ones_a, ones_c);
        check_range("o2_recover_0000", ones_c, 492, 532);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
